// File: rtl/darkroom_event_hub.sv
`default_nettype none
// ============================================================================
// Module      : darkroom_event_hub
// Description : Round-robin collector of per-sensor result words into a shared
//               event FIFO, drained over an Avalon-MM slave with an IRQ.
//               Optional macro DARKROOM_EVENT_TIMESTAMP_EN adds a per-event
//               32-bit cycle timestamp (read at address 7).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module darkroom_event_hub #(
    parameter int NUM_SENSORS = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [3:0]                        address,
    input  logic                              write,
    input  logic [31:0]                       writedata,
    input  logic                              read,
    output logic [31:0]                       readdata,
    output logic                              waitrequest,
    output logic                              interrupt_sender_irq,
    input  logic [NUM_SENSORS-1:0]            sensor_valid_i,
    input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_data_i
);

    localparam int          c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] c_unmapped = 32'hDEADBEEF;

    logic [NUM_SENSORS-1:0]            r_enable;
    logic [NUM_SENSORS-1:0]            r_pending;
    logic [NUM_SENSORS-1:0]            w_pending_next;
    logic [NUM_SENSORS-1:0]            w_enable_next;
    logic [NUM_SENSORS-1:0]            w_capture;
    logic [NUM_SENSORS-1:0]            w_grant_oh;
    logic [NUM_SENSORS*DATA_WIDTH-1:0] w_hold_flat;
    logic [4:0]                        r_ptr;
    logic [4:0]                        w_grant;
    logic                              w_grant_found;
    logic [DATA_WIDTH-1:0]             w_grant_data;
    int                                w_dist;
    int                                w_best;
    logic [15:0]                       r_thresh;
    logic [15:0]                       r_drop;
    logic [5:0]                        w_drop_n;
    logic [16:0]                       w_drop_sum;
    logic                              r_irq;

    logic [DATA_WIDTH-1:0]             r_mem_data [FIFO_DEPTH];
    logic [4:0]                        r_mem_chan [FIFO_DEPTH];
    logic [c_aw-1:0]                   r_wr_ptr;
    logic [c_aw-1:0]                   r_rd_ptr;
    logic [c_aw:0]                     r_count;
    logic [15:0]                       w_level;
    logic                              w_empty;
    logic                              w_full;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_flush;
    logic                              w_clr_drop;
    logic                              w_unused;

`ifdef DARKROOM_EVENT_TIMESTAMP_EN
    logic [31:0]                       r_cycle;
    logic [NUM_SENSORS*32-1:0]         w_ts_flat;
    logic [31:0]                       w_grant_ts;
    logic [31:0]                       r_mem_ts [FIFO_DEPTH];
`endif

    assign waitrequest          = 1'b0;
    assign interrupt_sender_irq = r_irq;
    assign w_unused             = ^writedata;

    assign w_level    = 16'(r_count);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (c_aw+1)'(FIFO_DEPTH));
    assign w_flush    = write && (address == 4'd5) && writedata[0];
    assign w_clr_drop = write && (address == 4'd5) && writedata[1];
    assign w_pop      = read && (address == 4'd1) && !w_empty && !w_flush;
    assign w_capture  = sensor_valid_i & r_enable;
    assign w_enable_next = (write && (address == 4'd3)) ? writedata[NUM_SENSORS-1:0] : r_enable;

    // Per-channel hold registers (and timestamps when enabled).
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_chan
        logic [DATA_WIDTH-1:0] r_hold;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                r_hold <= '0;
            else if (w_capture[gi])
                r_hold <= sensor_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        assign w_hold_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_hold;
`ifdef DARKROOM_EVENT_TIMESTAMP_EN
        logic [31:0] r_ts_hold;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                r_ts_hold <= '0;
            else if (w_capture[gi])
                r_ts_hold <= r_cycle;
        end
        assign w_ts_flat[gi*32 +: 32] = r_ts_hold;
`endif
    end

    // Round-robin: pick the pending channel with the smallest forward distance from r_ptr.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = '0;
        w_grant_oh    = '0;
        w_grant_data  = '0;
        w_best        = NUM_SENSORS;
        w_dist        = 0;
`ifdef DARKROOM_EVENT_TIMESTAMP_EN
        w_grant_ts    = '0;
`endif
        for (int j = 0; j < NUM_SENSORS; j++) begin
            w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_SENSORS - int'(r_ptr));
            if (r_pending[j] && (w_dist < w_best)) begin
                w_best        = w_dist;
                w_grant_found = 1'b1;
                w_grant       = 5'(j);
                w_grant_oh    = '0;
                w_grant_oh[j] = 1'b1;
                w_grant_data  = w_hold_flat[j*DATA_WIDTH +: DATA_WIDTH];
`ifdef DARKROOM_EVENT_TIMESTAMP_EN
                w_grant_ts    = w_ts_flat[j*32 +: 32];
`endif
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push = w_grant_found && (!w_full || w_pop) && !w_flush;

    always_comb begin
        w_pending_next = r_pending;
        w_drop_n       = '0;
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (w_capture[j] && r_pending[j] && !(w_push && w_grant_oh[j]))
                w_drop_n = w_drop_n + 6'd1;
            if (w_push && w_grant_oh[j])
                w_pending_next[j] = 1'b0;
            if (w_capture[j])
                w_pending_next[j] = 1'b1;
            if (!w_enable_next[j])
                w_pending_next[j] = 1'b0;
        end
        if (w_flush)
            w_pending_next = '0;
    end

    assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_n);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_enable  <= '1;
            r_pending <= '0;
            r_ptr     <= '0;
            r_thresh  <= '0;
            r_drop    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_enable  <= w_enable_next;
            r_pending <= w_pending_next;
            if (w_push)
                r_ptr <= (int'(w_grant) == NUM_SENSORS-1) ? 5'd0 : w_grant + 5'd1;
            if (write && (address == 4'd4))
                r_thresh <= writedata[15:0];
            if (w_clr_drop)
                r_drop <= '0;
            else
                r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_irq <= (r_thresh != 16'd0) && (w_level >= r_thresh);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_grant_data;
            r_mem_chan[r_wr_ptr] <= w_grant;
`ifdef DARKROOM_EVENT_TIMESTAMP_EN
            r_mem_ts[r_wr_ptr]   <= w_grant_ts;
`endif
        end
    end

`ifdef DARKROOM_EVENT_TIMESTAMP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cycle <= '0;
        else
            r_cycle <= r_cycle + 32'd1;
    end
`endif

    always_comb begin
        readdata = c_unmapped;
        case (address)
            4'd0: readdata = {14'd0, w_full, w_empty, w_level};
            4'd1: begin
                readdata = '0;
                if (!w_empty)
                    readdata[DATA_WIDTH-1:0] = r_mem_data[r_rd_ptr];
            end
            4'd2: readdata = w_empty ? 32'd0 : {27'd0, r_mem_chan[r_rd_ptr]};
            4'd3: begin
                readdata = '0;
                readdata[NUM_SENSORS-1:0] = r_enable;
            end
            4'd4: readdata = {16'd0, r_thresh};
            4'd5: readdata = 32'd0;
            4'd6: readdata = {16'd0, r_drop};
`ifdef DARKROOM_EVENT_TIMESTAMP_EN
            4'd7: readdata = w_empty ? 32'd0 : r_mem_ts[r_rd_ptr];
`endif
            default: readdata = c_unmapped;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_darkroom_event_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_darkroom_event_hub
// Description : Scoreboard bench for darkroom_event_hub (32 channels, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_darkroom_event_hub;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [3:0]    address;
    logic          write;
    logic [31:0]   writedata;
    logic          read;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic          irq;
    logic [31:0]   sensor_valid_i;
    logic [1023:0] sensor_data_i;

    int            checks   = 0;
    int            failures = 0;
    logic [36:0]   sb [$];
    logic [36:0]   e;
    logic [31:0]   v;

    always #5 clock = ~clock;

    darkroom_event_hub #(
        .NUM_SENSORS (32),
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .address              (address),
        .write                (write),
        .writedata            (writedata),
        .read                 (read),
        .readdata             (readdata),
        .waitrequest          (waitrequest),
        .interrupt_sender_irq (irq),
        .sensor_valid_i       (sensor_valid_i),
        .sensor_data_i        (sensor_data_i)
    );

    function automatic logic [31:0] ch_data(input int c, input logic [31:0] val);
        return val ^ (32'(c) << 24);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b0;
        #1;
        d = readdata;
    endtask

    task automatic pop_rd(output logic [31:0] d);
        address = 4'd1;
        read    = 1'b1;
        #1;
        d = readdata;
        tick();
        read = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic strobe1(input int c, input logic [31:0] d);
        sensor_valid_i    = 32'd0;
        sensor_valid_i[c] = 1'b1;
        sensor_data_i[c*32 +: 32] = d;
        tick();
        sensor_valid_i = 32'd0;
    endtask

    task automatic strobe_n(input logic [31:0] mask, input logic [31:0] val);
        for (int c = 0; c < 32; c++)
            sensor_data_i[c*32 +: 32] = ch_data(c, val);
        sensor_valid_i = mask;
        tick();
        sensor_valid_i = 32'd0;
    endtask

    task automatic do_reset();
        sensor_valid_i = 32'd0;
        sensor_data_i  = '0;
        write = 1'b0;
        read  = 1'b0;
        address = 4'd0;
        writedata = 32'd0;
        #2;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        sb.delete();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        rd(4'd0, v); checks++;
        if (v !== 32'h0001_0000) begin failures++; $display("FAIL reset_status got %h expected %h", v, 32'h0001_0000); end
        rd(4'd3, v); checks++;
        if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_enable got %h expected %h", v, 32'hFFFF_FFFF); end
        rd(4'd6, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL reset_drop got %h expected %h", v, 32'd0); end
        rd(4'd7, v); checks++;
`ifdef DARKROOM_EVENT_TIMESTAMP_EN
        if (v !== 32'd0) begin failures++; $display("FAIL reset_ts got %h expected %h", v, 32'd0); end
`else
        if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reset_addr7 got %h expected %h", v, 32'hDEAD_BEEF); end
`endif
        rd(4'd15, v); checks++;
        if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL unmapped got %h expected %h", v, 32'hDEAD_BEEF); end
        rd(4'd5, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL control_read got %h expected %h", v, 32'd0); end
        checks++;
        if (irq !== 1'b0 || waitrequest !== 1'b0) begin failures++; $display("FAIL reset_irq_wait got %b%b expected 00", irq, waitrequest); end
    endtask

    task automatic test_single();
        do_reset();
        strobe1(5, 32'h1234_5678);
        sb.push_back({5'd5, 32'h1234_5678});
        tick();
        rd(4'd0, v); checks++;
        if (v !== 32'h0000_0001) begin failures++; $display("FAIL single_level got %h expected %h", v, 32'h0000_0001); end
        e = sb.pop_front();
        rd(4'd2, v); checks++;
        if (v !== {27'd0, e[36:32]}) begin failures++; $display("FAIL single_chan got %h expected %h", v, {27'd0, e[36:32]}); end
        pop_rd(v); checks++;
        if (v !== e[31:0]) begin failures++; $display("FAIL single_data got %h expected %h", v, e[31:0]); end
        rd(4'd0, v); checks++;
        if (v !== 32'h0001_0000) begin failures++; $display("FAIL single_empty got %h expected %h", v, 32'h0001_0000); end
        rd(4'd1, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL empty_pop got %h expected %h", v, 32'd0); end
    endtask

    task automatic test_round_robin();
        do_reset();
        strobe_n(32'h0000_008A, 32'h0000_1111);
        sb.push_back({5'd1, ch_data(1, 32'h0000_1111)});
        sb.push_back({5'd3, ch_data(3, 32'h0000_1111)});
        sb.push_back({5'd7, ch_data(7, 32'h0000_1111)});
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            rd(4'd2, v); checks++;
            if (v !== {27'd0, e[36:32]}) begin failures++; $display("FAIL rr_chan[%0d] got %h expected %h", k, v, {27'd0, e[36:32]}); end
            pop_rd(v); checks++;
            if (v !== e[31:0]) begin failures++; $display("FAIL rr_data[%0d] got %h expected %h", k, v, e[31:0]); end
        end
        // pointer now 8: ch9 comes before the wrapped-around ch0
        strobe_n(32'h0000_0201, 32'h0000_2222);
        sb.push_back({5'd9, ch_data(9, 32'h0000_2222)});
        sb.push_back({5'd0, ch_data(0, 32'h0000_2222)});
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            rd(4'd2, v); checks++;
            if (v !== {27'd0, e[36:32]}) begin failures++; $display("FAIL wrap_chan[%0d] got %h expected %h", k, v, {27'd0, e[36:32]}); end
            pop_rd(v); checks++;
            if (v !== e[31:0]) begin failures++; $display("FAIL wrap_data[%0d] got %h expected %h", k, v, e[31:0]); end
        end
    endtask

    task automatic test_full();
        do_reset();
        strobe_n(32'h0000_000F, 32'h0000_3333);
        for (int c = 0; c < 4; c++)
            sb.push_back({5'(c), ch_data(c, 32'h0000_3333)});
        repeat (4) tick();
        strobe1(2, 32'hAAAA_0002);
        strobe1(2, 32'hBBBB_0002);
        sb.push_back({5'd2, 32'hBBBB_0002});
        rd(4'd0, v); checks++;
        if (v !== 32'h0002_0004) begin failures++; $display("FAIL full_status got %h expected %h", v, 32'h0002_0004); end
        rd(4'd6, v); checks++;
        if (v !== 32'd1) begin failures++; $display("FAIL full_drop got %h expected %h", v, 32'd1); end
        e = sb.pop_front();
        pop_rd(v); checks++;
        if (v !== e[31:0]) begin failures++; $display("FAIL full_pop0 got %h expected %h", v, e[31:0]); end
        rd(4'd0, v); checks++;
        if (v !== 32'h0002_0004) begin failures++; $display("FAIL full_refill got %h expected %h", v, 32'h0002_0004); end
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            rd(4'd2, v); checks++;
            if (v !== {27'd0, e[36:32]}) begin failures++; $display("FAIL full_chan[%0d] got %h expected %h", k, v, {27'd0, e[36:32]}); end
            pop_rd(v); checks++;
            if (v !== e[31:0]) begin failures++; $display("FAIL full_data[%0d] got %h expected %h", k, v, e[31:0]); end
        end
        wr(4'd5, 32'd2);
        rd(4'd6, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL drop_clear got %h expected %h", v, 32'd0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        strobe1(6, 32'h0606_0001);
        strobe1(6, 32'h0606_0002);
        sb.push_back({5'd6, 32'h0606_0001});
        sb.push_back({5'd6, 32'h0606_0002});
        repeat (2) tick();
        rd(4'd0, v); checks++;
        if (v !== 32'h0000_0002) begin failures++; $display("FAIL b2b_level got %h expected %h", v, 32'h0000_0002); end
        rd(4'd6, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL b2b_drop got %h expected %h", v, 32'd0); end
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            pop_rd(v); checks++;
            if (v !== e[31:0]) begin failures++; $display("FAIL b2b_data[%0d] got %h expected %h", k, v, e[31:0]); end
        end
    endtask

    task automatic test_irq();
        do_reset();
        wr(4'd4, 32'd3);
        strobe_n(32'h0000_0007, 32'h0000_4444);
        for (int c = 0; c < 3; c++)
            sb.push_back({5'(c), ch_data(c, 32'h0000_4444)});
        repeat (3) tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag got %b expected 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_high got %b expected 1", irq); end
        e = sb.pop_front();
        pop_rd(v); checks++;
        if (v !== e[31:0]) begin failures++; $display("FAIL irq_pop got %h expected %h", v, e[31:0]); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got %b expected 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_low got %b expected 0", irq); end
        wr(4'd4, 32'd0);
        strobe1(9, 32'h0909_0909);
        sb.push_back({5'd9, 32'h0909_0909});
        repeat (3) tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_thresh0 got %b expected 0", irq); end
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            rd(4'd2, v); checks++;
            if (v !== {27'd0, e[36:32]}) begin failures++; $display("FAIL irq_chan[%0d] got %h expected %h", k, v, {27'd0, e[36:32]}); end
            pop_rd(v); checks++;
            if (v !== e[31:0]) begin failures++; $display("FAIL irq_data[%0d] got %h expected %h", k, v, e[31:0]); end
        end
    endtask

    task automatic test_enable_flush();
        do_reset();
        wr(4'd3, 32'hFFFF_FFFB);
        rd(4'd3, v); checks++;
        if (v !== 32'hFFFF_FFFB) begin failures++; $display("FAIL enable_rb got %h expected %h", v, 32'hFFFF_FFFB); end
        strobe1(2, 32'h2222_2222);
        repeat (3) tick();
        rd(4'd0, v); checks++;
        if (v !== 32'h0001_0000) begin failures++; $display("FAIL disabled_ch got %h expected %h", v, 32'h0001_0000); end
        strobe_n(32'h0000_000B, 32'h0000_5555);
        repeat (4) tick();
        rd(4'd0, v); checks++;
        if (v !== 32'h0000_0003) begin failures++; $display("FAIL preflush got %h expected %h", v, 32'h0000_0003); end
        address   = 4'd5;
        write     = 1'b1;
        writedata = 32'd1;
        sensor_valid_i    = 32'd0;
        sensor_valid_i[4] = 1'b1;
        sensor_data_i[4*32 +: 32] = 32'h4444_4444;
        tick();
        write = 1'b0;
        sensor_valid_i = 32'd0;
        repeat (3) tick();
        rd(4'd0, v); checks++;
        if (v !== 32'h0001_0000) begin failures++; $display("FAIL flush_status got %h expected %h", v, 32'h0001_0000); end
        rd(4'd6, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL flush_drop got %h expected %h", v, 32'd0); end
    endtask

    initial begin
        reset_n = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_back_to_back();
        test_irq();
        test_enable_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
